// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_wb_arbiter_pkg;

   // Writeback arbitration priority: loads normally win, ALU wins after starving.
   typedef enum logic {
      PRIO_MEM = 1'b0,
      PRIO_ALU = 1'b1
   } wb_prio_e;

   // Architectural zero register; never written, never busy.
   localparam int REG_ZERO = '0;

   // Active level of the synchronous reset.
   localparam logic RESET = 1'b1;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_scoreboard.sv
// Busy-register scoreboard: tracks registers with an outstanding producer and
// raises issue_stall on RAW/WAW hazards. A register being written back this
// cycle is treated as free because the register file bypasses the write.
module regfile_scoreboard
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   input  logic [ADDRESS_WIDTH-1:0] issue_rs1,
   input  logic [ADDRESS_WIDTH-1:0] issue_rs2,
   input  logic [ADDRESS_WIDTH-1:0] issue_rd,
   input  logic                     write_en,
   input  logic [ADDRESS_WIDTH-1:0] write_id,
   output logic                     issue_stall
);

   localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] ZERO_ID = ADDRESS_WIDTH'(REG_ZERO);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] eff_busy;
   logic                issue_fire;

   // Hazard lookup and next busy vector; a set beats a clear on the same register.
   always_comb begin
      clr_mask = '0;
      if (write_en && (write_id != ZERO_ID)) begin
         clr_mask[write_id] = 1'b1;
      end
      eff_busy           = busy_q & ~clr_mask;
      eff_busy[REG_ZERO] = 1'b0;
      issue_stall = issue_valid && (rst != RESET) &&
                    (eff_busy[issue_rs1] | eff_busy[issue_rs2] | eff_busy[issue_rd]);
      issue_fire  = issue_valid && (rst != RESET) && !issue_stall;
      set_mask = '0;
      if (issue_fire && (issue_rd != ZERO_ID)) begin
         set_mask[issue_rd] = 1'b1;
      end
      busy_d           = (busy_q & ~clr_mask) | set_mask;
      busy_d[REG_ZERO] = 1'b0;
   end

   // Busy vector register.
   always_ff @(posedge clk) begin
      if (rst == RESET) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// Writeback controller for the 2R1W register file. Arbitrates the single
// write port between ALU and load results with starvation-bounded fixed
// priority (loads first), suppresses writes to x0, and hosts the busy-register
// scoreboard that stalls issue.
//
// Handshake: a source transfers in a cycle where valid && ready. ready is
// combinational from the valids, the priority state and rst only; at most one
// ready is high per cycle. Sources hold rd/data while valid && !ready.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDRESS_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0]    mem_data,
   input  logic                     issue_valid,
   input  logic [ADDRESS_WIDTH-1:0] issue_rs1,
   input  logic [ADDRESS_WIDTH-1:0] issue_rs2,
   input  logic [ADDRESS_WIDTH-1:0] issue_rd,
   output logic                     issue_stall,
   output logic                     write_en,
   output logic [ADDRESS_WIDTH-1:0] write_id,
   output logic [DATA_WIDTH-1:0]    write_data
);

   localparam logic [ADDRESS_WIDTH-1:0] ZERO_ID   = ADDRESS_WIDTH'(REG_ZERO);
   localparam logic [3:0]               LIMIT_CNT = 4'(STARVE_LIMIT);

   wb_prio_e                 state_q, state_d;
   logic [3:0]               starve_q, starve_d;
   logic                     write_en_q, write_en_d;
   logic [ADDRESS_WIDTH-1:0] write_id_q, write_id_d;
   logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
   logic                     alu_grant;
   logic                     mem_grant;

   // Grant selection, priority/starvation update and next writeback beat.
   always_comb begin
      alu_grant    = 1'b0;
      mem_grant    = 1'b0;
      state_d      = state_q;
      starve_d     = starve_q;
      write_en_d   = 1'b0;
      write_id_d   = '0;
      write_data_d = '0;
      if (rst != RESET) begin
         case (state_q)
            PRIO_MEM: begin
               if (mem_valid) begin
                  mem_grant = 1'b1;
                  if (alu_valid) begin
                     // ALU lost again; hand it priority once the limit is reached.
                     starve_d = starve_q + 4'd1;
                     if (starve_d >= LIMIT_CNT) begin
                        state_d = PRIO_ALU;
                     end
                  end else begin
                     starve_d = '0;
                  end
               end else begin
                  alu_grant = alu_valid;
                  starve_d  = '0;
               end
            end
            PRIO_ALU: begin
               // One ALU turn (or ALU went idle), then back to load priority.
               state_d   = PRIO_MEM;
               starve_d  = '0;
               alu_grant = alu_valid;
               mem_grant = !alu_valid && mem_valid;
            end
            default: begin
               state_d  = PRIO_MEM;
               starve_d = '0;
            end
         endcase
      end
      if (mem_grant && (mem_rd != ZERO_ID)) begin
         write_en_d   = 1'b1;
         write_id_d   = mem_rd;
         write_data_d = mem_data;
      end else if (alu_grant && (alu_rd != ZERO_ID)) begin
         write_en_d   = 1'b1;
         write_id_d   = alu_rd;
         write_data_d = alu_data;
      end
   end

   assign alu_ready = alu_grant;
   assign mem_ready = mem_grant;

   // Priority state, starvation counter and registered write port.
   always_ff @(posedge clk) begin
      if (rst == RESET) begin
         state_q      <= PRIO_MEM;
         starve_q     <= '0;
         write_en_q   <= 1'b0;
         write_id_q   <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         write_en_q   <= write_en_d;
         write_id_q   <= write_id_d;
         write_data_q <= write_data_d;
      end
   end

   assign write_en   = write_en_q;
   assign write_id   = write_id_q;
   assign write_data = write_data_q;

   regfile_scoreboard #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .issue_valid(issue_valid),
      .issue_rs1  (issue_rs1),
      .issue_rs2  (issue_rs2),
      .issue_rd   (issue_rd),
      .write_en   (write_en_q),
      .write_id   (write_id_q),
      .issue_stall(issue_stall)
   );

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a writeback scoreboard.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, mem_valid, issue_valid;
   logic          alu_ready, mem_ready, issue_stall;
   logic [AW-1:0] alu_rd, mem_rd, issue_rs1, issue_rs2, issue_rd;
   logic [DW-1:0] alu_data, mem_data;
   logic          write_en;
   logic [AW-1:0] write_id;
   logic [DW-1:0] write_data;

   logic [AW+DW-1:0] exp_q[$];
   int n_total = 0;
   int n_pass  = 0;

   regfile_wb_arbiter #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .issue_valid(issue_valid),
      .issue_rs1  (issue_rs1),
      .issue_rs2  (issue_rs2),
      .issue_rd   (issue_rd),
      .issue_stall(issue_stall),
      .write_en   (write_en),
      .write_id   (write_id),
      .write_data (write_data)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Scoreboard: every accepted nonzero-rd result must appear on the write port next cycle.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         chk("wb_en", 64'(write_en), 64'(exp_q.size() != 0));
         if (write_en && exp_q.size() != 0) begin
            chk("wb_beat", 64'({write_id, write_data}), 64'(exp_q.pop_front()));
         end
         chk("one_ready", 64'(alu_ready & mem_ready), 64'(0));
         if (mem_valid && mem_ready && mem_rd != '0) exp_q.push_back({mem_rd, mem_data});
         if (alu_valid && alu_ready && alu_rd != '0) exp_q.push_back({alu_rd, alu_data});
      end
   end

   logic [9:0] alu_win_pat;

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
      alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
      issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      alu_win_pat = 10'b10_0001_0000;

      // Reset state
      repeat (3) tick();
      chk("rst_we", 64'(write_en), 64'(0));
      chk("rst_wid", 64'(write_id), 64'(0));
      chk("rst_wdata", 64'(write_data), 64'(0));
      chk("rst_busy", 64'(dut.u_scoreboard.busy_q), 64'(0));
      chk("rst_state", 64'(dut.state_q), 64'(PRIO_MEM));
      rst = 1'b0;
      tick();

      // Single ALU result
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5_0001;
      at_neg();
      chk("alu_ready", 64'(alu_ready), 64'(1));
      chk("mem_ready_idle", 64'(mem_ready), 64'(0));
      tick();
      alu_valid = 1'b0;
      chk("wb1_en", 64'(write_en), 64'(1));
      chk("wb1_id", 64'(write_id), 64'(5));
      chk("wb1_data", 64'(write_data), 64'(32'hA5A5_0001));

      // Starvation bound: M,M,M,M,A,M,M,M,M,A
      alu_valid = 1'b1; mem_valid = 1'b1;
      alu_rd = 5'd10; mem_rd = 5'd20;
      alu_data = $urandom; mem_data = $urandom;
      for (int i = 0; i < 10; i++) begin
         at_neg();
         chk($sformatf("starve_alu%0d", i), 64'(alu_ready), 64'(alu_win_pat[i]));
         chk($sformatf("starve_mem%0d", i), 64'(mem_ready), 64'(!alu_win_pat[i]));
         tick();
         if (alu_win_pat[i]) begin
            alu_rd = alu_rd + 5'd1; alu_data = $urandom;
         end else begin
            mem_rd = mem_rd + 5'd1; mem_data = $urandom;
         end
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();

      // Write to x0 is accepted but suppressed
      alu_valid = 1'b1; alu_rd = '0; alu_data = 32'hFFFF_FFFF;
      at_neg();
      chk("x0_ready", 64'(alu_ready), 64'(1));
      tick();
      alu_valid = 1'b0;
      chk("x0_we", 64'(write_en), 64'(0));
      chk("x0_busy", 64'(dut.u_scoreboard.busy_q), 64'(0));

      // RAW on r7, released by the commit in the same cycle
      issue_valid = 1'b1; issue_rd = 5'd7;
      at_neg();
      chk("iss7_stall", 64'(issue_stall), 64'(0));
      tick();
      issue_rd = '0; issue_rs1 = 5'd7;
      at_neg();
      chk("raw7_stall", 64'(issue_stall), 64'(1));
      chk("busy7_set", 64'(dut.u_scoreboard.busy_q[7]), 64'(1));
      tick();
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = $urandom;
      at_neg();
      chk("raw7_hold", 64'(issue_stall), 64'(1));
      chk("c7_ready", 64'(alu_ready), 64'(1));
      tick();
      alu_valid = 1'b0;
      at_neg();
      chk("c7_we", 64'(write_en), 64'(1));
      chk("raw7_release", 64'(issue_stall), 64'(0));
      tick();
      issue_valid = 1'b0; issue_rs1 = '0;
      chk("busy7_clr", 64'(dut.u_scoreboard.busy_q[7]), 64'(0));

      // Set beats clear on r9, then WAW stall
      issue_valid = 1'b1; issue_rd = 5'd9;
      at_neg();
      chk("iss9_stall", 64'(issue_stall), 64'(0));
      tick();
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = $urandom;
      at_neg();
      chk("c9_ready", 64'(alu_ready), 64'(1));
      tick();
      alu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      at_neg();
      chk("iss9b_stall", 64'(issue_stall), 64'(0));
      chk("c9_wid", 64'(write_id), 64'(9));
      tick();
      issue_valid = 1'b0;
      chk("busy9_kept", 64'(dut.u_scoreboard.busy_q[9]), 64'(1));
      issue_valid = 1'b1; issue_rd = 5'd9;
      at_neg();
      chk("waw9_stall", 64'(issue_stall), 64'(1));
      tick();
      issue_valid = 1'b0; issue_rd = '0;

      // Reset mid-stream
      issue_valid = 1'b1; issue_rd = 5'd3;
      tick();
      issue_valid = 1'b0; issue_rd = '0;
      chk("busy3_set", 64'(dut.u_scoreboard.busy_q[3]), 64'(1));
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = $urandom;
      mem_valid = 1'b1; mem_rd = 5'd13; mem_data = $urandom;
      at_neg();
      chk("pre_rst_mem", 64'(mem_ready), 64'(1));
      tick();
      rst = 1'b1;
      issue_valid = 1'b1; issue_rs1 = 5'd3;
      tick();
      chk("mid_rst_we", 64'(write_en), 64'(0));
      chk("mid_rst_wid", 64'(write_id), 64'(0));
      chk("mid_rst_wdata", 64'(write_data), 64'(0));
      chk("mid_rst_alu_rdy", 64'(alu_ready), 64'(0));
      chk("mid_rst_mem_rdy", 64'(mem_ready), 64'(0));
      chk("mid_rst_stall", 64'(issue_stall), 64'(0));
      chk("mid_rst_busy", 64'(dut.u_scoreboard.busy_q), 64'(0));
      chk("mid_rst_state", 64'(dut.state_q), 64'(PRIO_MEM));
      chk("mid_rst_starve", 64'(dut.starve_q), 64'(0));
      rst = 1'b0;
      alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0; issue_rs1 = '0;
      tick();
      tick();
      chk("post_rst_we", 64'(write_en), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_regfile_wb_arbiter
